fetch_ctrl_i: RTL

//  Instruction-fetch initiator for the instruction memory controller port.

---
 rtl/fetch_ctrl_i_if.sv | 28 ++
 rtl/fetch_ctrl_i.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_i_if.sv
// Fetch port bundle: instruction-memory request/response, redirect input and decode-side FIFO head.
interface fetch_ctrl_i_if;
   logic [31:0] mem_address;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_datain;
   logic [3:0]  mem_byte_select;
   logic        mem_ready;
   logic [31:0] mem_dataout;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   modport master (
      output mem_address, mem_ren, mem_wen, mem_datain, mem_byte_select,
      output instr_valid, instr, instr_pc,
      input  mem_ready, mem_dataout, redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  mem_address, mem_ren, mem_wen, mem_datain, mem_byte_select,
      input  instr_valid, instr, instr_pc,
      output mem_ready, mem_dataout, redirect_valid, redirect_pc, instr_ready
   );
endinterface

// File: rtl/fetch_ctrl_i.sv
// Instruction fetch initiator: sequential fetch, small PC/instr FIFO, redirect with miss drain.
// Optional FETCH_PERF_CNT_EN adds accepted-word and stall-cycle counters.
module fetch_ctrl_i #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          FIFO_AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   fetch_ctrl_i_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]   perf_fetch_cnt,
   output logic [31:0]   perf_stall_cnt
`endif
);
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);
   localparam logic [31:0]      NOP     = 32'h0000_0013;

   typedef enum logic {FETCH, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [31:0]        target_q, target_d;
   logic [FIFO_AW-1:0] wr_q, rd_q;
   logic [FIFO_AW:0]   count_q;
   logic [31:0]        ins_mem [FIFO_DEPTH];
   logic [31:0]        pc_mem  [FIFO_DEPTH];

   logic [31:0] target;
   logic        pop_req, accept, push, pop, flush;

   assign bus.mem_wen         = 1'b0;
   assign bus.mem_datain      = 32'h0;
   assign bus.mem_byte_select = 4'b1111;

   assign target          = {bus.redirect_pc[31:2], 2'b00};
   assign bus.instr_valid = (count_q != '0);
   assign pop_req         = bus.instr_valid && bus.instr_ready;
   assign bus.instr       = bus.instr_valid ? ins_mem[rd_q] : NOP;
   assign bus.instr_pc    = bus.instr_valid ? pc_mem[rd_q]  : 32'h0;
   // Gate with reset so no request is visible while held in reset.
   assign bus.mem_ren     = reset && ((state_q == DRAIN) || (count_q < DEPTH_C) || pop_req);
   assign bus.mem_address = fetch_pc_q;
   assign accept          = bus.mem_ren && bus.mem_ready;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      target_d   = target_q;
      push       = 1'b0;
      pop        = 1'b0;
      flush      = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (bus.redirect_valid) begin
               flush = 1'b1;
               if (bus.mem_ren && !bus.mem_ready) begin
                  state_d  = DRAIN;
                  target_d = target;
               end else begin
                  fetch_pc_d = target;
               end
            end else begin
               pop = pop_req;
               if (accept) begin
                  push       = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end
         end
         DRAIN: begin
            // Word returned here belongs to the abandoned path and is dropped.
            if (bus.redirect_valid) begin
               flush    = 1'b1;
               target_d = target;
            end
            if (bus.mem_ready) begin
               state_d    = FETCH;
               fetch_pc_d = bus.redirect_valid ? target : target_q;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         target_q   <= RESET_PC;
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         target_q   <= target_d;
         if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
         end else begin
            if (push) wr_q <= wr_q + FIFO_AW'(1);
            if (pop)  rd_q <= rd_q + FIFO_AW'(1);
            unique case ({push, pop})
               2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
               2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ins_mem[wr_q] <= bus.mem_dataout;
         pc_mem[wr_q]  <= fetch_pc_q;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetch_cnt <= 32'h0;
         perf_stall_cnt <= 32'h0;
      end else begin
         if (push)                             perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (bus.mem_ren && !bus.mem_ready)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif
endmodule
